// File: rtl/audio_pdm_out.sv
// audio_pdm_out: sample strobe generator, sample capture, click-free gain ramp and 1-bit PDM modulator
//   clock      in   system clock
//   reset      in   asynchronous active-high reset
//   enable     in   audio on request (level)
//   sample_in  in   4-bit mixed sample from the sound generator
//   sample_ena out  one-cycle strobe at SAMPLE_RATE average rate
//   pdm_out    out  registered pulse-density audio bit
//   active     out  high whenever the ramp FSM is not OFF
//   gain       out  current 4-bit ramp gain
// Build option: define AUDIO_DITHER_EN to add 2-bit LFSR dither into the modulator.
module audio_pdm_out #(
   parameter int CLK_HZ      = 25000000,
   parameter int SAMPLE_RATE = 16384,
   parameter int ACC_W       = 24
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [3:0] sample_in,
   output logic       sample_ena,
   output logic       pdm_out,
   output logic       active,
   output logic [3:0] gain
);
   localparam longint INC_L = ((longint'(SAMPLE_RATE) << ACC_W) + longint'(CLK_HZ / 2)) / longint'(CLK_HZ);
   localparam logic [ACC_W-1:0] INC = ACC_W'(INC_L);
   typedef enum logic [1:0] {OFF, RAMP_UP, ON, RAMP_DOWN} state_t;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             carry;
   logic             sample_ena_q, ena_q, active_q, pdm_q;
   logic [3:0]       latch_q, gain_q, gain_d;
   logic [7:0]       macc_q, level;
   logic [8:0]       sum;
   logic [1:0]       dither;
   state_t           state_q, state_d, dir;
   assign {carry, acc_d} = {1'b0, acc_q} + {1'b0, INC};
   assign level = {4'b0, latch_q} * {4'b0, gain_q};
   assign sum = {1'b0, macc_q} + {1'b0, level} + {7'b0, dither};
`ifdef AUDIO_DITHER_EN
   logic [7:0] lfsr_q;
   // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
   always_ff @(posedge clock or posedge reset)
      if (reset) lfsr_q <= 8'hA5;
      else lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
   assign dither = state_q == OFF ? 2'b00 : lfsr_q[1:0];
`else
   assign dither = 2'b00;
`endif
   // dir is the state after the enable-driven transition; the strobe step then
   // follows dir, so a reversal and a strobe in one cycle move the new way.
   always_comb begin
      dir = state_q == OFF ? (enable ? RAMP_UP : OFF) :
            state_q == RAMP_DOWN ? (enable ? RAMP_UP : RAMP_DOWN) :
            (enable ? state_q : RAMP_DOWN);
      gain_d = !sample_ena_q ? gain_q :
               (dir == RAMP_UP && gain_q != 4'd15) ? gain_q + 4'd1 :
               (dir == RAMP_DOWN && gain_q != 4'd0) ? gain_q - 4'd1 : gain_q;
      state_d = (dir == RAMP_UP && gain_d == 4'd15) ? ON :
                (dir == RAMP_DOWN && gain_d == 4'd0) ? OFF : dir;
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         acc_q        <= '0;
         sample_ena_q <= 1'b0;
         ena_q        <= 1'b0;
         latch_q      <= 4'd0;
         gain_q       <= 4'd0;
         state_q      <= OFF;
         active_q     <= 1'b0;
         macc_q       <= 8'd0;
         pdm_q        <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         sample_ena_q <= carry;
         ena_q        <= sample_ena_q;
         // One cycle after the strobe so the generator's strobe-edge update is taken
         if (ena_q) latch_q <= sample_in;
         gain_q       <= gain_d;
         state_q      <= state_d;
         active_q     <= state_d != OFF;
         macc_q       <= state_q == OFF ? 8'd0 : sum[7:0];
         pdm_q        <= state_q != OFF && sum[8];
      end
   assign sample_ena = sample_ena_q;
   assign pdm_out    = pdm_q;
   assign active     = active_q;
   assign gain       = gain_q;
endmodule

// File: tb/tb_audio_pdm_out.sv
// tb_audio_pdm_out: directed self-checking bench for audio_pdm_out
module tb_audio_pdm_out;
   logic       clock, reset, enable;
   logic [3:0] sample_in;
   logic       sample_ena, pdm_out, active;
   logic [3:0] gain;
   int         checks = 0;
   int         errors = 0;
   audio_pdm_out #(.CLK_HZ(1024), .SAMPLE_RATE(64), .ACC_W(8)) dut (
      .clock(clock), .reset(reset), .enable(enable), .sample_in(sample_in),
      .sample_ena(sample_ena), .pdm_out(pdm_out), .active(active), .gain(gain)
   );
   initial clock = 1'b0;
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clock);
      #1;
   endtask
   task automatic wait_strobe();
      int n = 0;
      while (!sample_ena && n < 40) begin
         tick();
         n++;
      end
      if (!sample_ena) check("strobe_timeout", 0, 1);
   endtask
   task automatic strobes(input int n);
      for (int i = 0; i < n; i++) begin
         wait_strobe();
         tick();
      end
   endtask
   task automatic count_pdm(input int n, output int ones);
      ones = 0;
      for (int i = 0; i < n; i++) begin
         tick();
         ones += int'(pdm_out);
      end
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog got=0 want=1");
      $fatal(1, "timeout");
   end
   initial begin
      int pos[4];
      int pulses, first, ones;
      reset = 1'b1;
      enable = 1'b0;
      sample_in = 4'd0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         pulses += int'(sample_ena);
      end
      check("rst_pulses", pulses, 0);
      check("rst_pdm", pdm_out, 0);
      check("rst_active", active, 0);
      check("rst_gain", gain, 0);
      reset = 1'b0;
      sample_in = 4'd3;
      pulses = 0;
      pos = '{default: 0};
      for (int k = 1; k <= 64; k++) begin
         tick();
         if (sample_ena) begin
            if (pulses < 4) pos[pulses] = k;
            pulses++;
         end
      end
      check("strobe_count", pulses, 4);
      for (int i = 0; i < 4; i++) check("strobe_pos", pos[i], 16 * (i + 1));
      tick();
      check("latch_old", dut.latch_q, 3);
      sample_in = 4'd9;
      tick();
      check("latch_new", dut.latch_q, 9);
      sample_in = 4'd5;
      repeat (5) tick();
      check("latch_hold", dut.latch_q, 9);
      sample_in = 4'd15;
      enable = 1'b1;
      tick();
      check("up_active", active, 1);
      for (int g = 1; g <= 15; g++) begin
         strobes(1);
         check("ramp_up", gain, g);
      end
      check("state_on", dut.state_q, 2);
      strobes(1);
      check("gain_hold", gain, 15);
      repeat (40) tick();
      count_pdm(256, ones);
      check("duty_15", ones, 225);
      sample_in = 4'd0;
      repeat (40) tick();
      count_pdm(256, ones);
      check("duty_0", ones, 0);
      sample_in = 4'd8;
      repeat (40) tick();
      count_pdm(256, ones);
      check("duty_8", ones, 120);
      enable = 1'b0;
      strobes(15);
      check("down_gain", gain, 0);
      check("down_state", dut.state_q, 0);
      enable = 1'b1;
      strobes(6);
      check("up_to_6", gain, 6);
      check("up_state", dut.state_q, 1);
      enable = 1'b0;
      for (int g = 5; g >= 0; g--) begin
         strobes(1);
         check("reverse", gain, g);
      end
      check("rev_state", dut.state_q, 0);
      check("rev_active", active, 0);
      tick();
      check("rev_pdm", pdm_out, 0);
      count_pdm(20, ones);
      check("off_ones", ones, 0);
      enable = 1'b1;
      strobes(5);
      enable = 1'b0;
      strobes(2);
      check("down_to_3", gain, 3);
      check("rd_state", dut.state_q, 3);
      enable = 1'b1;
      strobes(1);
      check("reenable", gain, 4);
      check("reen_state", dut.state_q, 1);
      strobes(11);
      check("on_again", dut.state_q, 2);
      sample_in = 4'd15;
      repeat (40) tick();
      wait_strobe();
      check("pre_rst_ena", sample_ena, 1);
      check("pre_rst_gain", gain, 15);
      #2;
      reset = 1'b1;
      #1;
      check("arst_pdm", pdm_out, 0);
      check("arst_gain", gain, 0);
      check("arst_active", active, 0);
      check("arst_ena", sample_ena, 0);
      tick();
      tick();
      reset = 1'b0;
      first = 0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (sample_ena && first == 0) first = k;
      end
      check("restart_strobe", first, 16);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/audio_pdm_out.md
Name: audio_pdm_out

Overview:
Audio output stage downstream of the sound generator. It produces the generator's sample_ena strobe from the system clock using a fractional phase accumulator. It captures each 4-bit mixed sample and converts it to a 1-bit pulse-density stream for the board's audio pin. A soft on/off gain ramp suppresses clicks when audio is enabled or disabled.

Parameters:
CLK_HZ, 25000000, system clock frequency in Hz
SAMPLE_RATE, 16384, target strobe rate in Hz; must satisfy 2*SAMPLE_RATE <= CLK_HZ
ACC_W, 24, strobe phase accumulator width
(derived) INC = round(SAMPLE_RATE * 2^ACC_W / CLK_HZ), ACC_W bits, must be >= 1

Ports:
clock      input   1  system clock
reset      input   1  asynchronous, active-high reset
enable     input   1  audio on request (level)
sample_in  input   4  mixed sample from the sound generator
sample_ena output  1  one-cycle strobe to the sound generator, SAMPLE_RATE average rate
pdm_out    output  1  pulse-density audio bit, registered
active     output  1  high whenever the state is not OFF
gain       output  4  current ramp gain, for debug

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clock. All registers clear: phase acc 0, sample_ena 0, ena_d 0, sample latch 0, gain 0, modulator acc 0, pdm_out 0, state OFF, active 0.
- Strobe: each cycle {carry, acc} <= acc + INC. sample_ena is the registered carry. It is high for exactly one cycle per overflow, with period floor or ceil of 2^ACC_W/INC cycles.
- Capture: ena_d <= sample_ena. On the edge where ena_d = 1, the latch loads sample_in. This is one cycle after the strobe, so the upstream value updated on the strobe edge is captured.
- Level: level = latch * gain, 8 bits unsigned, range 0..225. The level is combinational from the registers.
- Modulator (first-order delta-sigma): each cycle {c, macc} <= macc + level (9-bit sum), and pdm_out <= c. In OFF, macc is held at 0 and pdm_out is forced to 0.
- FSM (gain changes only on edges where sample_ena = 1):
  - OFF: gain 0. If enable=1, go to RAMP_UP.
  - RAMP_UP: on each strobe, gain += 1. When gain reaches 15, go to ON. If enable=0, go to RAMP_DOWN; gain is kept and not reset.
  - ON: gain 15. If enable=0, go to RAMP_DOWN.
  - RAMP_DOWN: on each strobe, gain -= 1. When gain reaches 0, go to OFF. If enable=1, go to RAMP_UP from the current gain.
  - Transitions on enable are evaluated every cycle. The increment or decrement applies on strobe edges only, using the new state's direction when both happen in the same cycle.
  - gain never wraps: it saturates at 0 and 15.
- Full ramp: 15 strobes. The state is ON after the 15th strobe edge.
- Steady state: with gain 15 and sample 15, pdm_out duty is exactly 225/256 over any 256-cycle window. With sample 0, pdm_out stays 0.
- Reset mid-ramp: the block returns to OFF immediately and pdm_out goes to 0 asynchronously.

Optional Feature:
AUDIO_DITHER_EN
- Defined: an 8-bit Galois LFSR (polynomial x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances every cycle. The modulator adds lfsr[1:0] to level each cycle (max 228, no overflow of the 9-bit sum). The dither is suppressed in OFF. This breaks up idle tones.
- Undefined: no LFSR is present, and the modulator adds level only. The behaviour above is bit-exact.

Test Plan:
All tests use CLK_HZ=1024, SAMPLE_RATE=64, ACC_W=8, giving INC=16.
- Strobe: release reset, run 64 cycles -> sample_ena pulses exactly 4 times, each 16 cycles apart, first on cycle 16; no pulse during reset.
- Capture timing: drive sample_in=9 from the strobe edge on, with 3 before it -> latch=9 one cycle after the strobe; a value changed on other cycles is not captured.
- Ramp up: enable=1 from OFF with sample_in=15 -> gain steps 1..15 on consecutive strobes; active=1; state ON after the 15th strobe; gain holds at 15.
- Duty: in ON with sample_in=15, count pdm_out over 256 cycles -> exactly 225 ones; sample_in=0 -> 0 ones; sample_in=8 -> 120 ones.
- Reversal: enable=0 at gain=6 during RAMP_UP -> gain 5,4,..,0 on strobes, then OFF, active=0, pdm_out=0. Re-enable at gain=3 in RAMP_DOWN -> gain 4 on the next strobe.
- Async reset in ON mid-period -> pdm_out, gain, active and sample_ena go to 0 without a clock edge; after release the first strobe occurs on cycle 16.
